// File: rtl/rename_pkg.sv
// Shared rename-stage parameters and tag types for the rename unit, ROB and free list.
package rename_pkg;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int TAG_W     = $clog2(PHYS_REGS);
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = TAG_W + 1;

  typedef logic [TAG_W-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;
  typedef logic [CNT_W-1:0] fl_cnt_t;

  // Ring pointer increment, wrapping modulo DEPTH even if DEPTH is not a power of two.
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    if (p == fl_ptr_t'(DEPTH - 1)) begin
      return fl_ptr_t'(0);
    end else begin
      return p + fl_ptr_t'(1);
    end
  endfunction

endpackage

// File: rtl/freelist_dup_bitmap.sv
// One bit per physical tag marking it free; used to reject duplicate releases.
// Only instantiated when FREELIST_DUP_CHECK_EN is defined.
module freelist_dup_bitmap
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clr_en,
  input  phys_tag_t i_clr_tag,
  input  logic      i_set_en,
  input  phys_tag_t i_set_tag,
  input  phys_tag_t i_test_tag,
  output logic      o_test_hit
);

  localparam logic [PHYS_REGS-1:0] BIT_ONE   = PHYS_REGS'(1);
  localparam logic [PHYS_REGS-1:0] RST_FREE  = {{DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PHYS_REGS-1:0] r_free;
  logic [PHYS_REGS-1:0] w_clr_mask;
  logic [PHYS_REGS-1:0] w_set_mask;

  always_comb begin
    w_clr_mask = {PHYS_REGS{1'b0}};
    w_set_mask = {PHYS_REGS{1'b0}};
    if (i_clr_en) begin
      w_clr_mask = BIT_ONE << i_clr_tag;
    end else begin
      w_clr_mask = {PHYS_REGS{1'b0}};
    end
    if (i_set_en) begin
      w_set_mask = BIT_ONE << i_set_tag;
    end else begin
      w_set_mask = {PHYS_REGS{1'b0}};
    end
  end

  // Set wins over clear so a same-tag pop/push pair leaves the tag free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free <= RST_FREE;
    end else begin
      r_free <= (r_free & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_test_hit = r_free[i_test_tag];

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags: rename pops at the head, commit pushes at the tail.
// Optional duplicate-release filtering is enabled by defining FREELIST_DUP_CHECK_EN.
module phys_reg_freelist
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output phys_tag_t        alloc_tag,
  input  logic             rel_valid,
  input  phys_tag_t        rel_tag,
  output logic [TAG_W:0]   free_count,
  output logic             overflow_err,
  output logic             dup_err
);

  phys_tag_t r_ring [DEPTH];
  fl_ptr_t   r_head;
  fl_ptr_t   r_tail;
  fl_cnt_t   r_count;
  logic      r_ovf;

  logic      w_pop;
  logic      w_full;
  logic      w_dup;
  logic      w_rel_ok;
  logic      w_push;
  logic      w_ovf;

`ifdef FREELIST_DUP_CHECK_EN
  logic      w_dup_hit;
  logic      r_dup;

  freelist_dup_bitmap u_dup_bitmap (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_en   (w_pop),
    .i_clr_tag  (alloc_tag),
    .i_set_en   (w_push),
    .i_set_tag  (rel_tag),
    .i_test_tag (rel_tag),
    .o_test_hit (w_dup_hit)
  );

  assign w_dup = rel_valid && w_dup_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup <= 1'b0;
    end else begin
      r_dup <= w_dup;
    end
  end

  assign dup_err = r_dup;
`else
  assign w_dup   = 1'b0;
  assign dup_err = 1'b0;
`endif

  // A duplicate release is filtered before the full check, so it never also flags overflow.
  always_comb begin
    w_pop    = alloc_req && (r_count != fl_cnt_t'(0));
    w_full   = (r_count == fl_cnt_t'(DEPTH));
    w_rel_ok = rel_valid && !w_dup;
    w_push   = w_rel_ok && (!w_full || w_pop);
    w_ovf    = w_rel_ok && w_full && !w_pop;
  end

  // Tag storage; reset preloads the tags not held by the architectural map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ring[i] <= phys_tag_t'(ARCH_REGS + i);
      end
    end else if (w_push) begin
      r_ring[r_tail] <= rel_tag;
    end else begin
      r_ring[r_tail] <= r_ring[r_tail];
    end
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= fl_ptr_t'(0);
      r_tail  <= fl_ptr_t'(0);
      r_count <= fl_cnt_t'(DEPTH);
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end else begin
        r_head <= r_head;
      end
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end else begin
        r_tail <= r_tail;
      end
      case ({w_pop, w_push})
        2'b10:   r_count <= r_count - fl_cnt_t'(1);
        2'b01:   r_count <= r_count + fl_cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign alloc_valid  = (r_count != fl_cnt_t'(0));
  assign alloc_tag    = r_ring[r_head];
  assign free_count   = r_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Randomized and directed bench for phys_reg_freelist against a queue-based free-list model.
module tb_phys_reg_freelist;
  import rename_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           alloc_req;
  logic           alloc_valid;
  phys_tag_t      alloc_tag;
  logic           rel_valid;
  phys_tag_t      rel_tag;
  logic [TAG_W:0] free_count;
  logic           overflow_err;
  logic           dup_err;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  int mq[$];
  bit freemap [PHYS_REGS];
  int exp_ovf;
  int exp_dup;
  int last_popped = 0;

  phys_reg_freelist dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .rel_valid    (rel_valid),
    .rel_tag      (rel_tag),
    .free_count   (free_count),
    .overflow_err (overflow_err),
    .dup_err      (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of free tags plus a free bitmap for duplicate detection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back(ARCH_REGS + i);
      for (int i = 0; i < PHYS_REGS; i++) freemap[i] = (i >= ARCH_REGS);
      exp_ovf = 0;
      exp_dup = 0;
    end else begin
      bit pop, full, dup, acc;
      pop  = alloc_req && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      dup  = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
      dup  = rel_valid && freemap[rel_tag];
`endif
      acc     = rel_valid && !dup && (!full || pop);
      exp_ovf = (rel_valid && !dup && full && !pop) ? 1 : 0;
      exp_dup = dup ? 1 : 0;
      if (pop) begin
        last_popped = mq.pop_front();
        freemap[last_popped] = 1'b0;
      end
      if (acc) begin
        mq.push_back(int'(rel_tag));
        freemap[rel_tag] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("m_alloc_valid", int'(alloc_valid), (mq.size() != 0) ? 1 : 0);
      if (mq.size() != 0) chk("m_alloc_tag", int'(alloc_tag), mq[0]);
      chk("m_free_count", int'(free_count), mq.size());
      chk("m_overflow_err", int'(overflow_err), exp_ovf);
      chk("m_dup_err", int'(dup_err), exp_dup);
    end
  end

  task automatic cyc(input bit req, input bit rv, input int tag);
    alloc_req = req;
    rel_valid = rv;
    rel_tag   = phys_tag_t'(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_tag   = '0;
    rst_n     = 1'b1;
    #1;
    do_reset();
    started = 1'b1;

    chk("rst_alloc_tag", int'(alloc_tag), 32);
    chk("rst_alloc_valid", int'(alloc_valid), 1);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_overflow_err", int'(overflow_err), 0);
    chk("rst_dup_err", int'(dup_err), 0);

    for (int i = 0; i < 32; i++) begin
      chk("seq_alloc_tag", int'(alloc_tag), 32 + i);
      cyc(1'b1, 1'b0, 0);
    end
    chk("drained_valid", int'(alloc_valid), 0);
    chk("drained_count", int'(free_count), 0);

    cyc(1'b1, 1'b1, 5);
    chk("empty_rel_tag", int'(alloc_tag), 5);
    chk("empty_rel_valid", int'(alloc_valid), 1);
    chk("empty_rel_count", int'(free_count), 1);

    for (int t = 32; t < 63; t++) cyc(1'b0, 1'b1, t);
    chk("fill_count", int'(free_count), 32);
    cyc(1'b0, 1'b1, 7);
    chk("ovf_pulse", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), 32);
    cyc(1'b0, 1'b0, 0);
    chk("ovf_clear", int'(overflow_err), 0);
    cyc(1'b1, 1'b1, 7);
    chk("full_pop_push_err", int'(overflow_err), 0);
    chk("full_pop_push_count", int'(free_count), 32);
    chk("full_pop_push_tag", int'(alloc_tag), 32);

    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, last_popped);
      chk("steady_count", int'(free_count), 32);
    end

`ifdef FREELIST_DUP_CHECK_EN
    do_reset();
    cyc(1'b0, 1'b1, 40);
    chk("dup_pulse", int'(dup_err), 1);
    chk("dup_no_ovf", int'(overflow_err), 0);
    chk("dup_count", int'(free_count), 32);
    cyc(1'b1, 1'b1, 32);
    chk("dup_popped_pulse", int'(dup_err), 1);
    chk("dup_popped_count", int'(free_count), 31);
    cyc(1'b0, 1'b0, 0);
    chk("dup_clear", int'(dup_err), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int tag;
      tag = ($urandom_range(0, 1) == 0) ? last_popped : int'($urandom_range(0, PHYS_REGS - 1));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, tag);
    end

    do_reset();
    for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 0);
    alloc_req = 1'b0;
    chk("mid_count_before", int'(free_count), 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tag", int'(alloc_tag), 32);
    chk("mid_rst_valid", int'(alloc_valid), 1);
    chk("mid_rst_count", int'(free_count), 32);
    chk("mid_rst_ovf", int'(overflow_err), 0);
    chk("mid_rst_dup", int'(dup_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, last_popped);
    end
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
